imem_pipelined: RTL

Parametrised, pipelined successor to the instruction memory. Accepts one read or write request per cycle over a valid/ready handshake. Returns every accepted request as a response after a configurable latency, with per-byte write enables, alignment and range error reporting, and response back-pressure. Sits between the fetch unit (or loader) and the instruction storage array.

---
 rtl/imem_pipelined.sv | 105 ++++++++++
 1 files changed

// File: rtl/imem_pipelined.sv
// Pipelined instruction memory: one request per cycle over valid/ready, in-order
// responses after RD_LAT cycles, byte enables, alignment/range errors, response back-pressure.
module imem_pipelined #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF   = $clog2(BYTES);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic              vld;
        logic              err;
        logic [DATA_W-1:0] data;
    } stage_t;

    logic [DATA_W-1:0] mem_q [DEPTH];
    stage_t            stage_q [RD_LAT];
    stage_t            stage_d [RD_LAT];

    logic              stall_c;
    logic              accept_c;
    logic              misalign_c;
    logic              range_c;
    logic              err_c;
    logic              wr_en_c;
    logic              rd_en_c;
    logic [ADDR_W-1:0] word_idx_c;
    logic [IDX_W-1:0]  mem_idx_c;
    logic [DATA_W-1:0] rd_data_c;

    // Request decode; the read port is only enabled for a clean, accepted read.
    always_comb begin
        stall_c    = stage_q[RD_LAT-1].vld && !rsp_ready;
        req_ready  = !rst && !stall_c;
        accept_c   = req_valid && req_ready;
        word_idx_c = req_addr >> OFF;
        misalign_c = (req_addr & ADDR_W'(BYTES - 1)) != '0;
        range_c    = word_idx_c >= ADDR_W'(DEPTH);
        err_c      = misalign_c || range_c;
        mem_idx_c  = word_idx_c[IDX_W-1:0];
        wr_en_c    = accept_c && req_write && !err_c;
        rd_en_c    = accept_c && !req_write && !err_c;
        rd_data_c  = rd_en_c ? mem_q[mem_idx_c] : '0;
    end

    // Response pipeline: holds everything on stall, otherwise shifts one stage.
    always_comb begin
        for (int unsigned k = 0; k < RD_LAT; k++) begin
            stage_d[k] = stage_q[k];
        end
        if (!stall_c) begin
            stage_d[0].vld  = accept_c;
            stage_d[0].err  = accept_c && err_c;
            stage_d[0].data = rd_data_c;
            for (int unsigned k = 1; k < RD_LAT; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < RD_LAT; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < RD_LAT; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    // Storage array is intentionally not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (req_be[b]) begin
                    mem_q[mem_idx_c][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    assign rsp_valid = stage_q[RD_LAT-1].vld;
    assign rsp_err   = stage_q[RD_LAT-1].err;
    assign rsp_rdata = stage_q[RD_LAT-1].data;

endmodule
